// File: rtl/cpu6_ckpt_checker_pkg.sv
// Shared types and constants for the cpu6 checkpoint checker: state codes,
// fail-cause bit positions, per-entry flag bundle and default sizing.
package cpu6_ckpt_checker_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NCKPT_DEF = 4;
    localparam int TOW_DEF   = 16;

    localparam int CAUSE_GPR = 0;
    localparam int CAUSE_CSR = 1;
    localparam int CAUSE_TMO = 2;

    typedef enum logic [1:0] {
        CKPT_IDLE = 2'd0,
        CKPT_RUN  = 2'd1,
        CKPT_PASS = 2'd2,
        CKPT_FAIL = 2'd3
    } ckpt_state_t;

    typedef struct packed {
        logic chkreg;
        logic chkcsr;
        logic last;
    } ckpt_flags_t;

    function automatic logic [2:0] make_cause(input logic mis_reg,
                                              input logic mis_csr,
                                              input logic tmo);
        logic [2:0] c;
        c            = '0;
        c[CAUSE_GPR] = mis_reg;
        c[CAUSE_CSR] = mis_csr;
        c[CAUSE_TMO] = tmo;
        return c;
    endfunction

endpackage

// File: rtl/cpu6_ckpt_checker_if.sv
// Bundle of config, retire-stream, register-file tap and status signals between
// the checker (slave) and whoever loads/observes it (master).
interface cpu6_ckpt_checker_if
    import cpu6_ckpt_checker_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NCKPT = NCKPT_DEF,
    parameter int IDXW  = $clog2(NCKPT),
    parameter int TOW   = TOW_DEF
);
    logic            cfg_we;
    logic [IDXW-1:0] cfg_idx;
    logic [XLEN-1:0] cfg_pc;
    logic [4:0]      cfg_regidx;
    logic [XLEN-1:0] cfg_regval;
    logic [XLEN-1:0] cfg_csrval;
    logic            cfg_chkreg;
    logic            cfg_chkcsr;
    logic            cfg_last;
    logic            start;
    logic [TOW-1:0]  timeout_limit;
    logic            retire_valid;
    logic [XLEN-1:0] retire_pc;
    logic [4:0]      rf_raddr;
    logic [XLEN-1:0] rf_rdata;
    logic [XLEN-1:0] csr_rdata;
    logic            busy;
    logic            done;
    logic            pass;
    logic            fail;
    logic [IDXW-1:0] fail_ckpt;
    logic [2:0]      fail_cause;
    logic [IDXW-1:0] cur_ckpt;

    modport master (
        output cfg_we, cfg_idx, cfg_pc, cfg_regidx, cfg_regval, cfg_csrval,
               cfg_chkreg, cfg_chkcsr, cfg_last, start, timeout_limit,
               retire_valid, retire_pc, rf_rdata, csr_rdata,
        input  rf_raddr, busy, done, pass, fail, fail_ckpt, fail_cause, cur_ckpt
    );

    modport slave (
        input  cfg_we, cfg_idx, cfg_pc, cfg_regidx, cfg_regval, cfg_csrval,
               cfg_chkreg, cfg_chkcsr, cfg_last, start, timeout_limit,
               retire_valid, retire_pc, rf_rdata, csr_rdata,
        output rf_raddr, busy, done, pass, fail, fail_ckpt, fail_cause, cur_ckpt
    );

endinterface

// File: rtl/cpu6_ckpt_checker_table.sv
// Checkpoint table: NCKPT register entries, one write port, combinational read.
// Writes land on the next edge; no backpressure (the caller gates the write).
module cpu6_ckpt_table
    import cpu6_ckpt_checker_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NCKPT = NCKPT_DEF,
    parameter int IDXW  = $clog2(NCKPT)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [IDXW-1:0] widx,
    input  logic [XLEN-1:0] wpc,
    input  logic [4:0]      wregidx,
    input  logic [XLEN-1:0] wregval,
    input  logic [XLEN-1:0] wcsrval,
    input  ckpt_flags_t     wflags,
    input  logic [IDXW-1:0] ridx,
    output logic [XLEN-1:0] rpc,
    output logic [4:0]      rregidx,
    output logic [XLEN-1:0] rregval,
    output logic [XLEN-1:0] rcsrval,
    output ckpt_flags_t     rflags
);
    logic [XLEN-1:0] pc_q     [NCKPT];
    logic [4:0]      regidx_q [NCKPT];
    logic [XLEN-1:0] regval_q [NCKPT];
    logic [XLEN-1:0] csrval_q [NCKPT];
    ckpt_flags_t     flags_q  [NCKPT];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NCKPT; i++) begin
                pc_q[i]     <= '0;
                regidx_q[i] <= '0;
                regval_q[i] <= '0;
                csrval_q[i] <= '0;
                flags_q[i]  <= '0;
            end
        end else if (we && (32'(widx) < NCKPT)) begin
            pc_q[widx]     <= wpc;
            regidx_q[widx] <= wregidx;
            regval_q[widx] <= wregval;
            csrval_q[widx] <= wcsrval;
            flags_q[widx]  <= wflags;
        end
    end

    assign rpc     = pc_q[ridx];
    assign rregidx = regidx_q[ridx];
    assign rregval = regval_q[ridx];
    assign rcsrval = csrval_q[ridx];
    assign rflags  = flags_q[ridx];

endmodule

// File: rtl/cpu6_ckpt_checker.sv
// Retire-stream self-check monitor: walks an ordered checkpoint table, compares one GPR
// and one CSR at each checkpoint PC, reports pass/fail/timeout one cycle after the deciding cycle.
module cpu6_ckpt_checker
    import cpu6_ckpt_checker_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NCKPT = NCKPT_DEF,
    parameter int IDXW  = $clog2(NCKPT),
    parameter int TOW   = TOW_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    cpu6_ckpt_checker_if.slave   bus
);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCKPT - 1);

    ckpt_state_t     state_q, state_d;
    logic [IDXW-1:0] cur_q, cur_d;
    logic [TOW-1:0]  cnt_q, cnt_d;
    logic [IDXW-1:0] fckpt_q, fckpt_d;
    logic [2:0]      fcause_q, fcause_d;

    logic [XLEN-1:0] ent_pc;
    logic [4:0]      ent_regidx;
    logic [XLEN-1:0] ent_regval;
    logic [XLEN-1:0] ent_csrval;
    ckpt_flags_t     ent_flags;
    ckpt_flags_t     cfg_flags;
    logic            tab_we;

    logic            hit;
    logic            mis_reg;
    logic            mis_csr;
    logic [TOW-1:0]  cnt_inc;
    logic            tmo;

    // The table is frozen while a program is being checked.
    assign tab_we    = bus.cfg_we && (state_q != CKPT_RUN);
    assign cfg_flags = '{chkreg: bus.cfg_chkreg, chkcsr: bus.cfg_chkcsr, last: bus.cfg_last};

    cpu6_ckpt_table #(
        .XLEN  (XLEN),
        .NCKPT (NCKPT),
        .IDXW  (IDXW)
    ) u_table (
        .clk     (clk),
        .reset   (reset),
        .we      (tab_we),
        .widx    (bus.cfg_idx),
        .wpc     (bus.cfg_pc),
        .wregidx (bus.cfg_regidx),
        .wregval (bus.cfg_regval),
        .wcsrval (bus.cfg_csrval),
        .wflags  (cfg_flags),
        .ridx    (cur_q),
        .rpc     (ent_pc),
        .rregidx (ent_regidx),
        .rregval (ent_regval),
        .rcsrval (ent_csrval),
        .rflags  (ent_flags)
    );

    assign hit     = bus.retire_valid && (bus.retire_pc == ent_pc);
    assign mis_reg = ent_flags.chkreg && (bus.rf_rdata != ent_regval);
    assign mis_csr = ent_flags.chkcsr && (bus.csr_rdata != ent_csrval);
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + TOW'(1);
    // Fires on the cycle the idle count would reach the limit, so FAIL shows up exactly then.
    assign tmo     = (bus.timeout_limit != '0) && (cnt_inc >= bus.timeout_limit);

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        cnt_d    = cnt_q;
        fckpt_d  = fckpt_q;
        fcause_d = fcause_q;
        unique case (state_q)
            CKPT_RUN: begin
                if (hit) begin
                    if (mis_reg || mis_csr) begin
                        state_d  = CKPT_FAIL;
                        fckpt_d  = cur_q;
                        fcause_d = make_cause(mis_reg, mis_csr, 1'b0);
                    end else if (ent_flags.last || (cur_q == LAST_IDX)) begin
                        state_d = CKPT_PASS;
                    end else begin
                        cur_d = cur_q + IDXW'(1);
                        cnt_d = '0;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    if (tmo) begin
                        state_d  = CKPT_FAIL;
                        fckpt_d  = cur_q;
                        fcause_d = make_cause(1'b0, 1'b0, 1'b1);
                    end
                end
            end
            default: begin
                if (bus.start) begin
                    state_d  = CKPT_RUN;
                    cur_d    = '0;
                    cnt_d    = '0;
                    fckpt_d  = '0;
                    fcause_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= CKPT_IDLE;
            cur_q    <= '0;
            cnt_q    <= '0;
            fckpt_q  <= '0;
            fcause_q <= '0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            cnt_q    <= cnt_d;
            fckpt_q  <= fckpt_d;
            fcause_q <= fcause_d;
        end
    end

    assign bus.rf_raddr   = ent_regidx;
    assign bus.busy       = (state_q == CKPT_RUN);
    assign bus.pass       = (state_q == CKPT_PASS);
    assign bus.fail       = (state_q == CKPT_FAIL);
    assign bus.done       = bus.pass || bus.fail;
    assign bus.fail_ckpt  = fckpt_q;
    assign bus.fail_cause = fcause_q;
    assign bus.cur_ckpt   = cur_q;

endmodule

// File: tb/tb_cpu6_ckpt_checker.sv
// Directed plus randomized bench for cpu6_ckpt_checker against a cycle-level
// reference model of the checkpoint rules.
module tb_cpu6_ckpt_checker;
    localparam int XLEN  = 32;
    localparam int NCKPT = 4;
    localparam int IDXW  = 2;
    localparam int TOW   = 16;

    logic clk;
    logic reset;

    cpu6_ckpt_checker_if #(.XLEN(XLEN), .NCKPT(NCKPT), .IDXW(IDXW), .TOW(TOW)) bus();

    cpu6_ckpt_checker #(.XLEN(XLEN), .NCKPT(NCKPT), .IDXW(IDXW), .TOW(TOW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] regval;
        logic [31:0] csrval;
        logic [4:0]  regidx;
        bit          chkreg;
        bit          chkcsr;
        bit          last;
    } ent_t;

    ent_t m_tab [NCKPT];
    bit   m_run, m_pass, m_fail;
    int   m_idx, m_wait, m_fckpt, m_fcause;
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NCKPT; i++) begin
            m_tab[i].pc = 0; m_tab[i].regval = 0; m_tab[i].csrval = 0; m_tab[i].regidx = 0;
            m_tab[i].chkreg = 0; m_tab[i].chkcsr = 0; m_tab[i].last = 0;
        end
        m_run = 0; m_pass = 0; m_fail = 0;
        m_idx = 0; m_wait = 0; m_fckpt = 0; m_fcause = 0;
    endfunction

    // Predicts the effect of the upcoming clock edge from the inputs currently driven.
    function automatic void model_edge();
        ent_t e;
        bit   mr, mc;
        if (!reset) begin
            model_reset();
            return;
        end
        if (!m_run) begin
            if (bus.cfg_we) begin
                m_tab[bus.cfg_idx].pc     = bus.cfg_pc;
                m_tab[bus.cfg_idx].regidx = bus.cfg_regidx;
                m_tab[bus.cfg_idx].regval = bus.cfg_regval;
                m_tab[bus.cfg_idx].csrval = bus.cfg_csrval;
                m_tab[bus.cfg_idx].chkreg = bus.cfg_chkreg;
                m_tab[bus.cfg_idx].chkcsr = bus.cfg_chkcsr;
                m_tab[bus.cfg_idx].last   = bus.cfg_last;
            end
            if (bus.start) begin
                m_run = 1; m_pass = 0; m_fail = 0;
                m_idx = 0; m_wait = 0; m_fckpt = 0; m_fcause = 0;
            end
            return;
        end
        e = m_tab[m_idx];
        if (bus.retire_valid && bus.retire_pc == e.pc) begin
            mr = e.chkreg && (bus.rf_rdata != e.regval);
            mc = e.chkcsr && (bus.csr_rdata != e.csrval);
            if (mr || mc) begin
                m_run = 0; m_fail = 1; m_fckpt = m_idx;
                m_fcause = (mc ? 2 : 0) + (mr ? 1 : 0);
            end else if (e.last || m_idx == NCKPT - 1) begin
                m_run = 0; m_pass = 1;
            end else begin
                m_idx++;
                m_wait = 0;
            end
        end else begin
            if (m_wait < 65535) m_wait++;
            if (bus.timeout_limit != 0 && m_wait >= int'(bus.timeout_limit)) begin
                m_run = 0; m_fail = 1; m_fckpt = m_idx; m_fcause = 4;
            end
        end
    endfunction

    task automatic check_status();
        chk("status", {bus.busy, bus.done, bus.pass, bus.fail, bus.cur_ckpt, bus.fail_ckpt, bus.fail_cause},
            {m_run, m_pass | m_fail, m_pass, m_fail, IDXW'(m_idx), IDXW'(m_fckpt), 3'(m_fcause)});
        chk("rf_raddr", bus.rf_raddr, m_tab[m_idx].regidx);
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        check_status();
    endtask

    task automatic wr(input int idx, input logic [31:0] pc, input logic [4:0] ri,
                      input logic [31:0] rv, input logic [31:0] cv,
                      input bit cr, input bit cc, input bit last);
        bus.cfg_we = 1; bus.cfg_idx = idx[IDXW-1:0]; bus.cfg_pc = pc; bus.cfg_regidx = ri;
        bus.cfg_regval = rv; bus.cfg_csrval = cv;
        bus.cfg_chkreg = cr; bus.cfg_chkcsr = cc; bus.cfg_last = last;
        cyc();
        bus.cfg_we = 0;
    endtask

    task automatic retire(input logic [31:0] pc, input logic [31:0] rf, input logic [31:0] csr);
        bus.retire_valid = 1; bus.retire_pc = pc; bus.rf_rdata = rf; bus.csr_rdata = csr;
        cyc();
        bus.retire_valid = 0; bus.retire_pc = 32'hF000_0000;
    endtask

    // Retire traffic whose PCs never match any table entry used here.
    task automatic noise(input int n);
        for (int i = 0; i < n; i++) begin
            bus.retire_valid = 1'($urandom);
            bus.retire_pc    = 32'hF000_0000 | $urandom;
            bus.rf_rdata     = $urandom;
            bus.csr_rdata    = $urandom;
            cyc();
        end
        bus.retire_valid = 0;
    endtask

    task automatic go();
        bus.start = 1;
        cyc();
        bus.start = 0;
    endtask

    task automatic hit_ok();
        ent_t e;
        e = m_tab[m_idx];
        retire(e.pc, e.regval, e.csrval);
    endtask

    task automatic load_csrrwi();
        wr(0, 32'h1c, 5'd2, 32'h0, 32'h2,  1, 1, 0);
        wr(1, 32'h30, 5'd2, 32'h2, 32'h1e, 1, 1, 1);
    endtask

    task automatic do_reset();
        reset = 0;
        #1;
        model_reset();
        chk("rst_busy", bus.busy, 0);
        chk("rst_pass", bus.pass, 0);
        chk("rst_fail", bus.fail, 0);
        chk("rst_raddr", bus.rf_raddr, 0);
        cyc();
        reset = 1;
    endtask

    initial begin
        ent_t e;
        int   r;
        reset = 0;
        bus.cfg_we = 0; bus.cfg_idx = 0; bus.cfg_pc = 0; bus.cfg_regidx = 0;
        bus.cfg_regval = 0; bus.cfg_csrval = 0; bus.cfg_chkreg = 0; bus.cfg_chkcsr = 0;
        bus.cfg_last = 0; bus.start = 0; bus.timeout_limit = 0;
        bus.retire_valid = 0; bus.retire_pc = 32'hF000_0000; bus.rf_rdata = 0; bus.csr_rdata = 0;
        model_reset();
        #3;
        check_status();
        chk("reset_done", bus.done, 0);
        @(posedge clk);
        #1;
        reset = 1;

        // csrrwi program passes one cycle after the last hit
        load_csrrwi();
        go();
        noise(3);
        retire(32'h1c, 32'h0, 32'h2);
        chk("t1_cur_after_hit0", bus.cur_ckpt, 1);
        noise(2);
        chk("t1_pass_not_yet", bus.pass, 0);
        retire(32'h30, 32'h2, 32'h1e);
        chk("t1_pass", bus.pass, 1);
        chk("t1_cause", bus.fail_cause, 0);
        noise(3);
        chk("t1_pass_held", bus.pass, 1);

        // GPR mismatch at the second checkpoint
        go();
        retire(32'h1c, 32'h0, 32'h2);
        retire(32'h30, 32'h3, 32'h1e);
        chk("t2_fail", bus.fail, 1);
        chk("t2_fail_ckpt", bus.fail_ckpt, 1);
        chk("t2_cause", bus.fail_cause, 3'b001);
        chk("t2_no_pass", bus.pass, 0);

        // Timeout after exactly 8 RUN cycles; limit 0 never times out
        bus.timeout_limit = 8;
        go();
        noise(7);
        chk("t3_no_fail_yet", bus.fail, 0);
        noise(1);
        chk("t3_fail", bus.fail, 1);
        chk("t3_cause", bus.fail_cause, 3'b100);
        chk("t3_fail_ckpt", bus.fail_ckpt, 0);
        bus.timeout_limit = 0;
        go();
        noise(1000);
        chk("t3_busy_unlimited", bus.busy, 1);
        retire(32'h1c, 32'h0, 32'h2);
        retire(32'h30, 32'h2, 32'h1e);
        chk("t3_then_pass", bus.pass, 1);

        // Hit in the cycle the counter would reach the limit wins and restarts the count
        bus.timeout_limit = 5;
        go();
        noise(4);
        retire(32'h1c, 32'h0, 32'h2);
        chk("t4_no_fail", bus.fail, 0);
        chk("t4_cur", bus.cur_ckpt, 1);
        noise(4);
        chk("t4_counter_restarted", bus.busy, 1);
        noise(1);
        chk("t4_late_timeout", bus.fail_cause, 3'b100);
        chk("t4_late_ckpt", bus.fail_ckpt, 1);

        // Out-of-order PCs are ignored; repeats of a hit PC do not advance
        bus.timeout_limit = 0;
        go();
        retire(32'h30, 32'h2, 32'h1e);
        chk("t5_ordering", bus.cur_ckpt, 0);
        retire(32'h1c, 32'h0, 32'h2);
        retire(32'h1c, 32'h0, 32'h2);
        chk("t5_repeat", bus.cur_ckpt, 1);
        retire(32'h30, 32'h2, 32'h1e);
        chk("t5_pass_a", bus.pass, 1);

        // Four entries, no last flag: passes on the final index; entry 2 checks nothing
        for (int i = 0; i < NCKPT; i++)
            wr(i, 32'h100 + 32'(4 * i), 5'(i + 5), $urandom, $urandom, i != 2, i != 2, 0);
        go();
        for (int i = 0; i < NCKPT; i++) begin
            noise($urandom_range(0, 3));
            if (i == 2) retire(32'h108, $urandom, $urandom);
            else        hit_ok();
        end
        chk("t5_pass_wrap", bus.pass, 1);
        chk("t5_cur_frozen", bus.cur_ckpt, 3);

        // Writes during RUN are dropped; reset mid-RUN clears everything including the table
        go();
        wr(0, 32'hdead, 5'd9, 32'h1, 32'h1, 1, 1, 1);
        chk("t6_guard_raddr", bus.rf_raddr, 5);
        retire(32'h100, m_tab[0].regval, m_tab[0].csrval);
        chk("t6_guard_hit", bus.cur_ckpt, 1);
        do_reset();
        go();
        retire(32'h0, $urandom, $urandom);
        chk("t6_table_cleared", bus.cur_ckpt, 1);
        do_reset();
        load_csrrwi();
        go();
        retire(32'h1c, 32'h0, 32'h2);
        retire(32'h30, 32'h2, 32'h1e);
        chk("t6_reload_pass", bus.pass, 1);

        // Randomized rounds checked cycle by cycle against the model
        for (int round = 0; round < 8; round++) begin
            for (int i = 0; i < NCKPT; i++)
                wr(i, $urandom & 32'h0FFF_FFFC, 5'($urandom), $urandom, $urandom,
                   1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0);
            bus.timeout_limit = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(3, 12));
            go();
            for (int c = 0; c < 80; c++) begin
                r = $urandom_range(0, 9);
                if (r <= 3) begin
                    e = m_tab[m_idx];
                    retire(e.pc,
                           ($urandom_range(0, 5) == 0) ? e.regval ^ (32'h1 << $urandom_range(0, 31)) : e.regval,
                           ($urandom_range(0, 5) == 0) ? e.csrval ^ (32'h1 << $urandom_range(0, 31)) : e.csrval);
                end else if (r == 4) begin
                    go();
                end else if (r == 5) begin
                    wr($urandom_range(0, NCKPT - 1), $urandom & 32'h0FFF_FFFC, 5'($urandom),
                       $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
                end else begin
                    noise(1);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu6_ckpt_checker.md
Name: cpu6_ckpt_checker

Overview:
- Synthesizable on-chip self-check monitor for cpu6 directed programs. It replaces per-test hardcoded PC/register/CSR checks with a parametrised, runtime-loaded checkpoint table.
- Watches the retire stream. At each checkpoint PC it compares one GPR value and one CSR value (e.g. mepc) against expected values.
- Reports pass/fail/timeout with the failing checkpoint index and cause.
- Sits in soc_top beside the core. Its results can drive the VGA/LED status.

Parameters:
- XLEN, 32, data/PC width
- NCKPT, 4, number of checkpoint entries (>=2)
- IDXW, $clog2(NCKPT), checkpoint index width
- TOW, 16, timeout counter width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- cfg_we  in  1  write checkpoint entry
- cfg_idx  in  IDXW  entry index
- cfg_pc  in  XLEN  checkpoint PC
- cfg_regidx  in  5  GPR to check
- cfg_regval  in  XLEN  expected GPR value
- cfg_csrval  in  XLEN  expected CSR value
- cfg_chkreg  in  1  enable GPR compare
- cfg_chkcsr  in  1  enable CSR compare
- cfg_last  in  1  entry is final checkpoint
- start  in  1  arm checker (pulse)
- timeout_limit  in  TOW  cycles allowed between hits; 0 = disabled
- retire_valid  in  1  instruction retiring this cycle
- retire_pc  in  XLEN  PC of retiring instruction
- rf_raddr  out  5  GPR read address (combinational = current entry regidx)
- rf_rdata  in  XLEN  GPR value, same cycle
- csr_rdata  in  XLEN  observed CSR value, same cycle
- busy  out  1  state RUN
- done  out  1  state PASS or FAIL
- pass  out  1  state PASS
- fail  out  1  state FAIL
- fail_ckpt  out  IDXW  index of entry being checked at failure
- fail_cause  out  3  bit0 GPR mismatch, bit1 CSR mismatch, bit2 timeout
- cur_ckpt  out  IDXW  current entry index

Behaviour:
- Reset: state IDLE. Table entries, cur_ckpt, timeout counter, fail_ckpt, fail_cause all 0. busy/done/pass/fail 0.
- States: IDLE, RUN, PASS, FAIL (2-bit encoding).
- Table writes:
  - accepted only in IDLE/PASS/FAIL;
  - ignored in RUN;
  - write takes effect on the next edge.
- start in IDLE/PASS/FAIL -> RUN. Clears cur_ckpt, counter, fail_ckpt, fail_cause. start in RUN is ignored.
- RUN, hit = retire_valid && retire_pc == entry[cur_ckpt].pc.
  - Only the current entry is evaluated; checkpoints are strictly ordered.
- On hit, evaluate combinationally in the same cycle:
  - mr = chkreg && rf_rdata != regval;
  - mc = chkcsr && csr_rdata != csrval.
- Next edge after a hit:
  - if mr|mc: FAIL, fail_cause={0,mc,mr}, fail_ckpt=cur_ckpt;
  - else if entry.last or cur_ckpt==NCKPT-1: PASS;
  - else cur_ckpt+1 and counter cleared.
- Latency: pass/fail asserted exactly 1 cycle after the hit cycle.
- Timeout:
  - counter increments each RUN cycle without a hit;
  - when counter reaches timeout_limit (limit != 0): FAIL, fail_cause=3'b100, fail_ckpt=cur_ckpt;
  - counter saturates, no wrap.
- A hit and the timeout in the same cycle: the hit wins.
- rf_raddr always equals entry[cur_ckpt].regidx, in every state.
- Entry with chkreg=chkcsr=0: a PC hit alone advances.
- Repeated retirement of the same PC after a hit: counts only if it matches the next entry.
- PASS/FAIL are held until start or reset. Outputs hold their values there; cur_ckpt is frozen.
- Reset asserted mid-RUN: immediate return to reset values. The table is cleared, so it must be reloaded.

Decomposition:
- Shared defines.v: state codes (CKPT_IDLE/RUN/PASS/FAIL), fail_cause bit positions, default NCKPT/TOW.
- One sub-module, cpu6_ckpt_table:
  - NCKPT-entry register array;
  - write port (cfg_*);
  - combinational read by cur_ckpt;
  - async active-low reset.
- The FSM, compare logic and timeout counter stay in the top.

Test Plan:
1. csrrwi pass:
   - ckpt0 = pc 0x1c, x2=0, csr=0x2;
   - ckpt1 = pc 0x30, x2=0x2, csr=0x1e, last;
   - both hits with correct data -> pass=1 one cycle after the 0x30 hit, fail_cause=0.
2. GPR mismatch: same table, rf_rdata=0x3 at pc 0x30 -> fail=1, fail_ckpt=1, fail_cause=3'b001; pass stays 0.
3. Timeout: timeout_limit=8, no retire of 0x1c -> fail=1 after 8 RUN cycles, fail_cause=3'b100, fail_ckpt=0. With limit=0 and no hits for 1000 cycles, busy stays 1.
4. Hit-vs-timeout collision: limit=5, hit on ckpt0 in the cycle the counter reaches 5 -> no fail; cur_ckpt=1 and counter=0.
5. Ordering and last-index wrap:
   - retire pc 0x30 before 0x1c -> ignored, cur_ckpt stays 0;
   - with NCKPT=4 and no last flags, 4 clean hits -> pass.
6. Reset and config guard:
   - cfg_we during RUN leaves the entry unchanged;
   - reset low mid-RUN -> busy/pass/fail=0 and table cleared;
   - start after reload runs cleanly.
